// File: rtl/spi_responder_pkg.sv
// Shared constants and types for the SPI responder peripheral.
package spi_responder_pkg;
  localparam int SPI_WIDTH = 8;
  localparam int OUT_BUSY  = 15;
  localparam int OUT_VALID = 14;
  localparam int OUT_OVR   = 13;

  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/sync_edge.sv
// SYNC-stage synchronizer with one extra copy for rise/fall pulse detection.
module sync_edge #(
  parameter int   SYNC    = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  // bits [SYNC-1:0] are the synchronizer chain, bit SYNC is the delayed copy
  logic [SYNC:0] syncPipe;

  always_ff @(posedge clk) begin
    if (reset) syncPipe <= {(SYNC+1){RST_VAL}};
    else       syncPipe <= {syncPipe[SYNC-1:0], d};
  end

  assign q    = syncPipe[SYNC-1];
  assign rise =  syncPipe[SYNC-1] & ~syncPipe[SYNC];
  assign fall = ~syncPipe[SYNC-1] &  syncPipe[SYNC];
endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 slave peripheral: CPU loads the reply byte, polls received bytes via out.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH,
  parameter int SYNC  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [15:0]      out,
  input  logic             sck,
  input  logic             csn,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(SYNC + 2);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [AW-1:0] ARM_FULL = AW'(SYNC + 1);

  logic sckS, sckRise, sckFall;
  logic csnS, csnRise, csnFall;
  logic mosiS, mosiRise, mosiFall;

  sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) uSck (
    .clk(clk), .reset(reset), .d(sck), .q(sckS), .rise(sckRise), .fall(sckFall));
  sync_edge #(.SYNC(SYNC), .RST_VAL(1'b1)) uCsn (
    .clk(clk), .reset(reset), .d(csn), .q(csnS), .rise(csnRise), .fall(csnFall));
  sync_edge #(.SYNC(SYNC), .RST_VAL(1'b0)) uMosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosiS), .rise(mosiRise), .fall(mosiFall));

  logic unusedSync;
  assign unusedSync = ^{sckS, mosiRise, mosiFall};

  state_t           state;
  logic [WIDTH-1:0] txHold, shiftTx, shiftRx, rxByte;
  logic [CW-1:0]    bitCnt;
  logic             gotBit, rxValid, overrun, busy, misoOe;
  logic             armed;
  logic [AW-1:0]    armCnt;

  logic             done;
  logic [WIDTH-1:0] rxNext;
  logic [15:0]      outNext;

  always_comb begin
    rxNext = {shiftRx[WIDTH-2:0], mosiS};
    done   = (state == SHIFT) && !csnRise && sckRise && (bitCnt == LAST);
    outNext = '0;
    outNext[OUT_BUSY]    = busy;
    outNext[OUT_VALID]   = rxValid;
    outNext[OUT_OVR]     = overrun;
    outNext[WIDTH-1:0]   = rxByte;
  end

  assign miso    = misoOe ? shiftTx[WIDTH-1] : 1'b1;
  assign miso_oe = misoOe;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txHold  <= '0;
      shiftTx <= '0;
      shiftRx <= '0;
      rxByte  <= '0;
      bitCnt  <= '0;
      gotBit  <= 1'b0;
      rxValid <= 1'b0;
      overrun <= 1'b0;
      busy    <= 1'b0;
      misoOe  <= 1'b0;
      armed   <= 1'b0;
      armCnt  <= '0;
      out     <= '0;
    end else begin
      out <= outNext;
      if (load) txHold <= in;
      rxValid <= done | (rxValid & ~load);
      overrun <= ~load & (overrun | (done & rxValid));
      if (done) rxByte <= rxNext;

      // After reset, a frame may only start once csn has been seen high on the
      // pin itself, not merely through the preset synchronizer chain.
      if (!armed) begin
        if (csnRise)                armed  <= 1'b1;
        else if (!csnS)             armCnt <= '0;
        else if (armCnt == ARM_FULL) armed <= 1'b1;
        else                        armCnt <= armCnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (csnFall && armed) begin
            state   <= SHIFT;
            shiftTx <= txHold;
            busy    <= 1'b1;
            misoOe  <= 1'b1;
            gotBit  <= sckRise;
            bitCnt  <= sckRise ? CW'(1) : '0;
            if (sckRise) shiftRx <= rxNext;
          end
        end
        SHIFT: begin
          if (csnRise) begin
            state  <= IDLE;
            bitCnt <= '0;
            busy   <= 1'b0;
            misoOe <= 1'b0;
          end else if (sckRise) begin
            shiftRx <= rxNext;
            gotBit  <= 1'b1;
            bitCnt  <= (bitCnt == LAST) ? '0 : bitCnt + 1'b1;
          end else if (sckFall) begin
            if (bitCnt != '0) shiftTx <= shiftTx << 1;
            else if (gotBit)  shiftTx <= txHold;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: directed frame table, corner sequences, randomized frames vs model.
module tb_spi_responder;
  logic        clk = 1'b0;
  logic        reset, load, sck, csn, mosi;
  logic [7:0]  din;
  logic [15:0] dout;
  logic        miso, misoOe;

  int nCmp = 0;
  int nBad = 0;

  spi_responder dut (
    .clk(clk), .reset(reset), .load(load), .in(din), .out(dout),
    .sck(sck), .csn(csn), .mosi(mosi), .miso(miso), .miso_oe(misoOe));

  always #5 clk = ~clk;

  typedef struct {
    logic        doLoad;
    logic [7:0]  ld;
    int          nBits;
    logic [31:0] mo;
    logic [31:0] expMi;
    logic [15:0] expLow;
    logic [15:0] expOut;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cpuLoad(input logic [7:0] b);
    @(negedge clk); load = 1'b1; din = b;
    @(negedge clk); load = 1'b0;
  endtask

  // Master bit at clk/8: mosi set, sck low 4 clks, sample miso on rise, sck high 4 clks.
  task automatic sendBit(input logic b, input logic doLd, input logic [7:0] ld, output logic mb);
    mosi = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    mb = miso;
    if (doLd) begin
      // land the strobe on the cycle the synchronized rising edge is acted on
      @(negedge clk); @(negedge clk);
      load = 1'b1; din = ld;
      @(negedge clk); load = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    sck = 1'b0;
  endtask

  task automatic runFrame(input logic doLoad, input logic [7:0] ld, input int nBits,
                          input logic [31:0] mo, input logic ldLast, input logic [7:0] ldVal,
                          output logic [31:0] mi, output logic [15:0] lowOut);
    logic b;
    if (doLoad) cpuLoad(ld);
    @(negedge clk); csn = 1'b0;
    repeat (8) @(negedge clk);
    mi = '0;
    for (int i = 0; i < nBits; i++) begin
      sendBit(mo[nBits-1-i], ldLast && (i == nBits-1), ldVal, b);
      mi = {mi[30:0], b};
    end
    repeat (6) @(negedge clk);
    lowOut = dout;
    repeat (2) @(negedge clk);
    csn = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  logic [31:0] mi, expMi, mo, tmp;
  logic [15:0] lowOut;
  logic [7:0]  mTx, mRx, b8;
  logic        mV, mO, doL, bitDummy;
  int          nb;

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8,  32'h3C,   32'hA5,   16'hC03C, 16'h403C};
    vecs[1] = '{1'b0, 8'h00, 16, 32'h1122, 32'hA5A5, 16'hE022, 16'h6022};
    vecs[2] = '{1'b1, 8'h3C, 5,  32'h1F,   32'h07,   16'h8022, 16'h0022};
    vecs[3] = '{1'b0, 8'h00, 8,  32'h81,   32'h3C,   16'hC081, 16'h4081};
    vecs[4] = '{1'b1, 8'h96, 8,  32'h7E,   32'h96,   16'hC07E, 16'h407E};
    vecs[5] = '{1'b0, 8'h00, 8,  32'h00,   32'h96,   16'hE000, 16'h6000};

    reset = 1'b1; load = 1'b0; din = '0; sck = 1'b0; csn = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_out", 32'(dout), 32'h0);
    chk("rst_oe", 32'(misoOe), 32'h0);
    chk("rst_miso", 32'(miso), 32'h1);
    repeat (20) @(negedge clk);

    // idle: sck activity with csn high does nothing
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom);
      repeat (4) @(negedge clk); sck = 1'b1;
      repeat (4) @(negedge clk); sck = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("idle_out", 32'(dout), 32'h0);
    chk("idle_oe", 32'(misoOe), 32'h0);
    chk("idle_miso", 32'(miso), 32'h1);

    for (int v = 0; v < 6; v++) begin
      runFrame(vecs[v].doLoad, vecs[v].ld, vecs[v].nBits, vecs[v].mo, 1'b0, 8'h00, mi, lowOut);
      chk($sformatf("vec%0d_miso", v), mi, vecs[v].expMi);
      chk($sformatf("vec%0d_low", v), 32'(lowOut), 32'(vecs[v].expLow));
      chk($sformatf("vec%0d_out", v), 32'(dout), 32'(vecs[v].expOut));
    end

    // load coinciding with byte completion: valid stays, overrun cleared, reply not disturbed
    runFrame(1'b0, 8'h00, 8, 32'hC3, 1'b1, 8'h5A, mi, lowOut);
    chk("ldcoll_miso", mi, 32'h96);
    chk("ldcoll_low", 32'(lowOut), 32'hC0C3);
    chk("ldcoll_out", 32'(dout), 32'h40C3);
    runFrame(1'b0, 8'h00, 8, 32'h00, 1'b0, 8'h00, mi, lowOut);
    chk("ldnext_miso", mi, 32'h5A);
    chk("ldnext_low", 32'(lowOut), 32'hE000);
    chk("ldnext_out", 32'(dout), 32'h6000);

    // reset mid-frame with csn held low: rest of the frame is ignored
    @(negedge clk); csn = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) sendBit(1'b1, 1'b0, 8'h00, bitDummy);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) sendBit(1'b1, 1'b0, 8'h00, bitDummy);
    repeat (6) @(negedge clk);
    chk("midrst_out", 32'(dout), 32'h0);
    chk("midrst_oe", 32'(misoOe), 32'h0);
    chk("midrst_miso", 32'(miso), 32'h1);
    csn = 1'b1;
    repeat (16) @(negedge clk);
    chk("midrst_idle", 32'(dout), 32'h0);
    runFrame(1'b0, 8'h00, 8, 32'h5C, 1'b0, 8'h00, mi, lowOut);
    chk("postrst_miso", mi, 32'h00);
    chk("postrst_low", 32'(lowOut), 32'hC05C);
    chk("postrst_out", 32'(dout), 32'h405C);

    // randomized frames against a byte-level model
    mTx = 8'h00; mRx = 8'h5C; mV = 1'b1; mO = 1'b0;
    for (int f = 0; f < 30; f++) begin
      doL = 1'($urandom);
      b8  = 8'($urandom);
      case ($urandom_range(0, 3))
        0: nb = 8;
        1: nb = 16;
        2: nb = 24;
        default: nb = $urandom_range(1, 15);
      endcase
      mo = $urandom;
      if (doL) begin mTx = b8; mV = 1'b0; mO = 1'b0; end
      expMi = '0;
      for (int i = 0; i < nb; i++) expMi = {expMi[30:0], mTx[7-(i%8)]};
      for (int k = 0; k < nb/8; k++) begin
        tmp = mo >> (nb - 8*(k+1));
        if (mV) mO = 1'b1;
        mRx = tmp[7:0];
        mV = 1'b1;
      end
      runFrame(doL, b8, nb, mo, 1'b0, 8'h00, mi, lowOut);
      chk($sformatf("rnd%0d_miso", f), mi, expMi);
      chk($sformatf("rnd%0d_low", f), 32'(lowOut), 32'({1'b1, mV, mO, 5'b0, mRx}));
      chk($sformatf("rnd%0d_out", f), 32'(dout), 32'({1'b0, mV, mO, 5'b0, mRx}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
